// File: rtl/simd_mem_pkg.sv
// Shared types and default sizing for the vector load/store unit.
package simd_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  localparam int unsigned DefDataSize   = 32;
  localparam int unsigned DefAddrSize   = 32;
  localparam int unsigned DefMemorySize = 10020;
  localparam int unsigned DefLanes      = 4;

  // Lane index width; a single-lane build still needs a 1-bit counter.
  function automatic int unsigned lane_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_lsu_agu.sv
// Strided address generator for vector_lsu: one lane address per step.
// LSU_BOUNDS_CHECK_EN enables the out-of-range flag on the current lane address.
module vector_lsu_agu
  import simd_mem_pkg::*;
#(
  parameter int unsigned addressingSize = DefAddrSize,
  parameter int unsigned memorySize     = DefMemorySize,
  parameter int unsigned lanes          = DefLanes,
  localparam int unsigned LaneW         = lane_idx_w(lanes)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      step_i,
  input  logic [addressingSize-1:0] base_i,
  input  logic [addressingSize-1:0] stride_i,
  output logic [addressingSize-1:0] addr_o,
  output logic [LaneW-1:0]          lane_o,
  output logic                      last_o,
  output logic                      oob_o
);

  logic [addressingSize-1:0] addr_q, addr_d;
  logic [addressingSize-1:0] stride_q, stride_d;
  logic [LaneW-1:0]          lane_q, lane_d;

  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    lane_d   = lane_q;
    if (start_i) begin
      addr_d   = base_i;
      stride_d = stride_i;
      lane_d   = '0;
    end else if (step_i) begin
      // Natural wrap modulo 2^addressingSize.
      addr_d = addr_q + stride_q;
      lane_d = lane_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      stride_q <= '0;
      lane_q   <= '0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
      lane_q   <= lane_d;
    end
  end

  assign addr_o = addr_q;
  assign lane_o = lane_q;
  assign last_o = (lane_q == LaneW'(lanes - 1));

`ifdef LSU_BOUNDS_CHECK_EN
  assign oob_o = (addr_q >= addressingSize'(memorySize));
`else
  assign oob_o = 1'b0;
`endif

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: serialises a strided lanes-wide request onto a single-word memory port.
// LSU_BOUNDS_CHECK_EN enables per-lane bounds checking against memorySize.
module vector_lsu
  import simd_mem_pkg::*;
#(
  parameter int unsigned dataSize       = DefDataSize,
  parameter int unsigned addressingSize = DefAddrSize,
  parameter int unsigned memorySize     = DefMemorySize,
  parameter int unsigned lanes          = DefLanes
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_store,
  input  logic [addressingSize-1:0]          req_base,
  input  logic [addressingSize-1:0]          req_stride,
  input  logic [lanes-1:0][dataSize-1:0]     req_wdata,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [lanes-1:0][dataSize-1:0]     resp_rdata,
  output logic                               resp_err,
  output logic                               mem_write_enable,
  output logic [addressingSize-1:0]          mem_DataAdr,
  output logic [dataSize-1:0]                mem_toWrite_data,
  input  logic [dataSize-1:0]                mem_read_data
);

  localparam int unsigned LaneW = lane_idx_w(lanes);

  lsu_state_e                   state_q, state_d;
  logic                         store_q, store_d;
  logic [lanes-1:0][dataSize-1:0] wdata_q, wdata_d;
  logic [lanes-1:0][dataSize-1:0] rdata_q;
  logic                         cap_en_q, cap_oob_q;
  logic [LaneW-1:0]             cap_idx_q;

  logic                         agu_start, agu_step, agu_last, agu_oob, access;
  logic [addressingSize-1:0]    agu_addr;
  logic [LaneW-1:0]             agu_lane;

  vector_lsu_agu #(
    .addressingSize (addressingSize),
    .memorySize     (memorySize),
    .lanes          (lanes)
  ) u_agu (
    .clk      (clk),
    .rst      (rst),
    .start_i  (agu_start),
    .step_i   (agu_step),
    .base_i   (req_base),
    .stride_i (req_stride),
    .addr_o   (agu_addr),
    .lane_o   (agu_lane),
    .last_o   (agu_last),
    .oob_o    (agu_oob)
  );

  always_comb begin
    state_d   = state_q;
    store_d   = store_q;
    wdata_d   = wdata_q;
    agu_start = 1'b0;
    agu_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d   = req_store;
          wdata_d   = req_wdata;
          agu_start = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        agu_step = 1'b1;
        if (agu_last) state_d = store_q ? RESP : DRAIN;
      end
      DRAIN:   state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      wdata_q <= wdata_d;
    end
  end

  // Read data lags the address by one cycle, so capture uses last cycle's lane tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_en_q  <= 1'b0;
      cap_idx_q <= '0;
      cap_oob_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      cap_en_q  <= access && !store_q;
      cap_idx_q <= agu_lane;
      cap_oob_q <= agu_oob;
      if (cap_en_q) rdata_q[cap_idx_q] <= cap_oob_q ? '0 : mem_read_data;
    end
  end

`ifdef LSU_BOUNDS_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (agu_start) begin
      err_q <= 1'b0;
    end else if (access && agu_oob) begin
      err_q <= 1'b1;
    end
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign access           = (state_q == ACCESS);
  assign req_ready        = (state_q == IDLE);
  assign resp_valid       = (state_q == RESP);
  assign resp_rdata       = rdata_q;
  assign mem_write_enable = access && store_q && !agu_oob;
  assign mem_DataAdr      = access ? agu_addr : '0;
  assign mem_toWrite_data = (access && store_q) ? wdata_q[agu_lane] : '0;

endmodule

// File: tb/tb_vector_lsu.sv
// Directed self-checking bench for vector_lsu with a one-cycle-latency word memory model.
module tb_vector_lsu;

  localparam int unsigned Lanes = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;

  typedef logic [Lanes-1:0][DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_store;
  logic [AW-1:0] req_base, req_stride;
  vec_t          req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  vec_t          resp_rdata;
  logic          mem_write_enable;
  logic [AW-1:0] mem_DataAdr;
  logic [DW-1:0] mem_toWrite_data;
  logic [DW-1:0] mem_read_data;

  vector_lsu #(
    .dataSize       (DW),
    .addressingSize (AW),
    .memorySize     (10020),
    .lanes          (Lanes)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_store        (req_store),
    .req_base         (req_base),
    .req_stride       (req_stride),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_write_enable (mem_write_enable),
    .mem_DataAdr      (mem_DataAdr),
    .mem_toWrite_data (mem_toWrite_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, one-cycle registered read.
  logic [DW-1:0] mem [0:16383];
  int            wr_count = 0;

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_DataAdr[13:0]] <= mem_toWrite_data;
      wr_count               <= wr_count + 1;
    end
    mem_read_data <= mem[mem_DataAdr[13:0]];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int            lat;
  vec_t          r_data;
  logic          r_err;
  logic [AW-1:0] adr_log [Lanes];
  logic          we_log  [Lanes];
  logic [DW-1:0] wd_log  [Lanes];

  task automatic run_req(input logic st, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                         input vec_t wd, input int hold);
    vec_t held;
    bit   stable;
    check("req_ready_idle", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_store  = st;
    req_base   = base;
    req_stride = stride;
    req_wdata  = wd;
    step();
    // Scramble request fields after accept; the unit must have latched them.
    req_valid  = 1'b0;
    req_store  = ~st;
    req_base   = 32'h5555_5555;
    req_stride = 32'h0000_0777;
    req_wdata  = '1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n <= Lanes) begin
        adr_log[n-1] = mem_DataAdr;
        we_log[n-1]  = mem_write_enable;
        wd_log[n-1]  = mem_toWrite_data;
      end
      if (resp_valid) begin
        lat = n;
        break;
      end
      step();
    end
    check("resp_seen", lat != 0, 1'b1);
    if (lat == 0) return;
    held   = resp_rdata;
    r_err  = resp_err;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      step();
      if (!(resp_valid && resp_rdata == held && !req_ready && resp_err == r_err)) stable = 1'b0;
    end
    if (hold > 0) check("resp_hold_stable", stable, 1'b1);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("req_ready_after_hs", req_ready, 1'b1);
    check("resp_valid_after_hs", resp_valid, 1'b0);
    r_data = held;
  endtask

  initial begin
    vec_t v1, v2, v3, exp_v;
    int   w0;
    bit   any_resp;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_base   = '0;
    req_stride = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    #2;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_we", mem_write_enable, 1'b0);
    check("rst_adr", mem_DataAdr, 32'd0);
    check("rst_wdata", mem_toWrite_data, 32'd0);
    check("rst_rdata", resp_rdata, 128'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Store base=100 stride=1; response carries the previous (reset) load vector.
    v1[0] = 32'h0000_00A0; v1[1] = 32'h0000_00B1; v1[2] = 32'h0000_00C2; v1[3] = 32'h0000_00D3;
    w0 = wr_count;
    run_req(1'b1, 32'd100, 32'd1, v1, 0);
    check("st_lat", lat, 5);
    for (int k = 0; k < Lanes; k++) begin
      check("st_adr", adr_log[k], 32'(100 + k));
      check("st_we", we_log[k], 1'b1);
      check("st_wd", wd_log[k], v1[k]);
    end
    check("st_wcount", wr_count - w0, 4);
    check("st_rdata_prev", r_data, 128'd0);
    check("st_err", r_err, 1'b0);

    // Load it back with 3 cycles of back-pressure on the response.
    w0 = wr_count;
    run_req(1'b0, 32'd100, 32'd1, '0, 3);
    check("ld_lat", lat, 6);
    check("ld_rdata", r_data, v1);
    check("ld_no_we", {we_log[0], we_log[1], we_log[2], we_log[3]}, 4'b0000);
    check("ld_wcount", wr_count - w0, 0);

    // Strided store then load at 200,204,208,212.
    v2[0] = 32'h1111_0000; v2[1] = 32'h2222_0001; v2[2] = 32'h3333_0002; v2[3] = 32'h4444_0003;
    run_req(1'b1, 32'd200, 32'd4, v2, 0);
    check("st2_rdata_prev", r_data, v1);
    run_req(1'b0, 32'd200, 32'd4, '0, 0);
    for (int k = 0; k < Lanes; k++) check("ld2_adr", adr_log[k], 32'(200 + 4 * k));
    check("ld2_rdata", r_data, v2);

    // Address wrap at the top of the address space.
    run_req(1'b0, 32'hFFFF_FFFE, 32'd1, '0, 0);
    check("wrap_adr0", adr_log[0], 32'hFFFF_FFFE);
    check("wrap_adr1", adr_log[1], 32'hFFFF_FFFF);
    check("wrap_adr2", adr_log[2], 32'h0000_0000);
    check("wrap_adr3", adr_log[3], 32'h0000_0001);

    // Stride 0 reads the same word every lane.
    run_req(1'b0, 32'd100, 32'd0, '0, 0);
    exp_v[0] = 32'hA0; exp_v[1] = 32'hA0; exp_v[2] = 32'hA0; exp_v[3] = 32'hA0;
    check("s0_rdata", r_data, exp_v);
    check("s0_adr3", adr_log[3], 32'd100);
    check("s0_err", r_err, 1'b0);

    // Store straddling the end of memory.
    v3[0] = 32'hCAFE_0000; v3[1] = 32'hCAFE_0001; v3[2] = 32'hCAFE_0002; v3[3] = 32'hCAFE_0003;
    w0 = wr_count;
    run_req(1'b1, 32'd10018, 32'd1, v3, 0);
`ifdef LSU_BOUNDS_CHECK_EN
    check("bnd_wcount", wr_count - w0, 2);
    check("bnd_we", {we_log[0], we_log[1], we_log[2], we_log[3]}, 4'b1100);
    check("bnd_err", r_err, 1'b1);
    run_req(1'b0, 32'd10018, 32'd1, '0, 0);
    exp_v[0] = v3[0]; exp_v[1] = v3[1]; exp_v[2] = 32'd0; exp_v[3] = 32'd0;
    check("bnd_ld_rdata", r_data, exp_v);
    check("bnd_ld_err", r_err, 1'b1);
`else
    check("nobnd_wcount", wr_count - w0, 4);
    check("nobnd_adr3", adr_log[3], 32'd10021);
    check("nobnd_err", r_err, 1'b0);
`endif

    // Reset while lane 1 of a store is on the bus.
    v3[0] = 32'h11; v3[1] = 32'h22; v3[2] = 32'h33; v3[3] = 32'h44;
    w0 = wr_count;
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_base   = 32'd300;
    req_stride = 32'd1;
    req_wdata  = v3;
    step();
    req_valid = 1'b0;
    step();
    check("mid_adr_lane1", mem_DataAdr, 32'd301);
    check("mid_we_lane1", mem_write_enable, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_we", mem_write_enable, 1'b0);
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_resp_valid", resp_valid, 1'b0);
    step();
    rst = 1'b0;
    any_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (resp_valid || !req_ready) any_resp = 1'b1;
    end
    check("mid_no_resp", any_resp, 1'b0);
    check("mid_wcount", wr_count - w0, 1);
    check("mid_rdata_cleared", resp_rdata, 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vector_lsu.md
VECTOR_LSU -- requirements
Module: vector_lsu

Interface
REQ-001 SHALL have parameter dataSize, default 32, element width in bits.
REQ-002 SHALL have parameter addressingSize, default 32, address width in bits.
REQ-003 SHALL have parameter memorySize, default 10020, number of addressable words in data_memory.
REQ-004 SHALL have parameter lanes, default 4, vector elements per request.
REQ-005 SHALL have ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1=store, 0=load.
- req_base  in  addressingSize  word address of lane 0.
- req_stride  in  addressingSize  word stride between lanes, unsigned.
- req_wdata  in  lanes x dataSize  store vector; lane i at index i.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  lanes x dataSize  load vector.
- resp_err  out  1  bounds error on any lane.
- mem_write_enable  out  1  to data_memory write_enable.
- mem_DataAdr  out  addressingSize  to data_memory DataAdr.
- mem_toWrite_data  out  dataSize  to data_memory toWrite_data (vecSize=1).
- mem_read_data  in  dataSize  from data_memory read_data.

Function
REQ-006 SHALL implement FSM IDLE -> ACCESS -> (load: DRAIN) -> RESP -> IDLE.
REQ-007 req_ready SHALL be 1 only in IDLE; accept on req_valid&&req_ready; all req_* fields latched at accept.
REQ-008 ACCESS SHALL last exactly lanes cycles; in cycle k (k=0..lanes-1) mem_DataAdr = base + k*stride, modulo 2^addressingSize.
REQ-009 Store: mem_write_enable=1 and mem_toWrite_data=lane k during each ACCESS cycle; 0 in all other states.
REQ-010 Load: mem_write_enable=0; data_memory read latency is one cycle; lane k SHALL be captured from mem_read_data on the edge ending cycle k+1 (DRAIN captures lane lanes-1).
REQ-011 Store goes ACCESS->RESP; load goes ACCESS->DRAIN->RESP; resp_valid first high lanes+1 (store) or lanes+2 (load) cycles after the accept edge.
REQ-012 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL hold stable until resp_valid&&resp_ready; then IDLE next cycle.
REQ-013 resp_rdata SHALL be don't-care-free: for stores it returns the previous load vector unchanged.
REQ-014 req_valid during non-IDLE states SHALL be ignored (no queuing); req_ready rises the cycle after response handshake.
REQ-015 stride 0 SHALL access the same word lanes times (valid, not an error).

Reset
REQ-016 On rst: state IDLE, req_ready=1, resp_valid=0, resp_err=0, mem_write_enable=0, mem_DataAdr=0, mem_toWrite_data=0, resp_rdata=0, immediately and asynchronously.
REQ-017 rst during ACCESS SHALL abort: no further writes, no response issued, partially captured data discarded.

Configuration
REQ-018 With LSU_BOUNDS_CHECK_EN defined: any lane address >= memorySize SHALL suppress that lane's write, force that lane's load data to 0, and set resp_err=1 for the response.
REQ-019 Without LSU_BOUNDS_CHECK_EN: no check, resp_err tied 0, address passed through unmodified.

Structure
REQ-020 Package simd_mem_pkg SHALL hold the FSM state enum (IDLE, ACCESS, DRAIN, RESP) and default width/lane constants.
REQ-021 Address generation (base, stride, lane counter, bounds compare) SHALL live in sub-module vector_lsu_agu.

Verification
REQ-022 Reset asserted mid-store, lane 1 -> mem_write_enable=0 same cycle, resp_valid never asserts, req_ready=1.
REQ-023 Store base=100, stride=1, data {A0,B1,C2,D3}; then load base=100 -> resp_rdata={A0,B1,C2,D3}, store resp at accept+5, load resp at accept+6.
REQ-024 Load base=200, stride=4 -> mem_DataAdr sequence 200,204,208,212 on consecutive cycles.
REQ-025 resp_ready held 0 for 3 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout.
REQ-026 base=32'hFFFF_FFFE, stride=1 -> addresses FFFF_FFFE, FFFF_FFFF, 0, 1.
REQ-027 LSU_BOUNDS_CHECK_EN, store base=10018, stride=1 -> writes only at 10018,10019; resp_err=1.
